// File: rtl/rk4_stream_packer.sv
// Packs multi-channel RK4 solver samples into a little-endian byte stream for a
// UART transmitter, appending an end-of-stream marker after the last sample of a run.
module rk4_stream_packer #(
    parameter int          WORD_W     = 32,
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [63:0] EOS_WORD   = 64'h0000_0000_DEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_CH*WORD_W-1:0]     s_data,
    input  logic                         s_last,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         abort,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [7:0]                   tx_byte,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [15:0]                  sample_cnt
);

    localparam int DW  = NUM_CH * WORD_W;
    localparam int BPW = WORD_W / 8;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int NB  = NUM_CH * BPW;
    localparam int CW  = $clog2(NB + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] EOS  = 2'd3;

    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [DW-1:0] EOS_SH    = DW'(EOS_WORD[WORD_W-1:0]);
    localparam logic [CW-1:0] EOS_BYTES = CW'(BPW);
    localparam logic [CW-1:0] ONE_BYTE  = CW'(1);

    logic [DW:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [LW-1:0]   r_level;
    logic            r_rdy_en;

    logic [1:0]      r_state;
    logic [DW-1:0]   r_sh;
    logic [CW-1:0]   r_cnt;
    logic            r_last;
    logic            r_drop;
    logic            r_txv;
    logic [15:0]     r_scnt;

    logic            w_abort;
    logic            w_push;
    logic            w_pop;
    logic            w_xfer;
    logic [DW-1:0]   w_rd_data;
    logic            w_rd_last;
    logic [DW-1:0]   w_pack;
    logic [CW-1:0]   w_nb;
    logic [15:0]     w_scnt_inc;

    // The EOS marker is never cut short, so abort has no effect once it is on the wire.
    assign w_abort    = abort && (r_state != EOS);
    assign s_ready    = r_rdy_en && (r_level != FULL_LVL);
    assign w_push     = s_valid && s_ready && !w_abort;
    assign w_pop      = (r_state == LOAD) && !w_abort;
    assign w_xfer     = r_txv && tx_ready;
    assign {w_rd_last, w_rd_data} = r_mem[r_rp];
    assign w_scnt_inc = (r_scnt == 16'hFFFF) ? r_scnt : r_scnt + 16'd1;

    assign tx_valid   = r_txv;
    assign tx_byte    = r_txv ? r_sh[7:0] : 8'h00;
    assign busy       = (r_level != '0) || (r_state != IDLE);
    assign fifo_level = r_level;
    assign sample_cnt = r_scnt;

    // Compact enabled channels so the lowest enabled one lands in the LSBs.
    always_comb begin
        w_pack = '0;
        w_nb   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_en[k]) begin
                w_pack = (w_pack << WORD_W) | DW'(w_rd_data[k*WORD_W +: WORD_W]);
                w_nb   = w_nb + CW'(BPW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {s_last, s_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_level  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_abort) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_level <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop)  r_rp <= r_rp + AW'(1);
                r_level <= r_level + LW'(w_push) - LW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
            r_txv   <= 1'b0;
            r_scnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_abort) begin
                        r_state <= EOS;
                        r_sh    <= EOS_SH;
                        r_cnt   <= EOS_BYTES;
                        r_txv   <= 1'b1;
                        r_drop  <= 1'b0;
                    end else if (r_level != '0) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= EOS;
                        r_sh    <= EOS_SH;
                        r_cnt   <= EOS_BYTES;
                        r_txv   <= 1'b1;
                        r_drop  <= 1'b0;
                    end else if (w_nb != '0) begin
                        r_last  <= w_rd_last;
                        r_sh    <= w_pack;
                        r_cnt   <= w_nb;
                        r_txv   <= 1'b1;
                        r_state <= SEND;
                    end else begin
                        r_scnt <= w_scnt_inc;
                        if (w_rd_last) begin
                            r_state <= EOS;
                            r_sh    <= EOS_SH;
                            r_cnt   <= EOS_BYTES;
                            r_txv   <= 1'b1;
                            r_drop  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                SEND: begin
                    // A stalled byte stays on the wire after abort; r_drop remembers to bail out once it goes.
                    if (w_xfer) begin
                        if (w_abort || r_drop) begin
                            r_state <= EOS;
                            r_sh    <= EOS_SH;
                            r_cnt   <= EOS_BYTES;
                            r_txv   <= 1'b1;
                            r_drop  <= 1'b0;
                        end else if (r_cnt == ONE_BYTE) begin
                            r_scnt <= w_scnt_inc;
                            if (r_last) begin
                                r_state <= EOS;
                                r_sh    <= EOS_SH;
                                r_cnt   <= EOS_BYTES;
                                r_txv   <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_txv   <= 1'b0;
                            end
                        end else begin
                            r_sh  <= r_sh >> 8;
                            r_cnt <= r_cnt - ONE_BYTE;
                        end
                    end else if (w_abort) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (r_cnt == ONE_BYTE) begin
                            r_state <= IDLE;
                            r_txv   <= 1'b0;
                            r_scnt  <= '0;
                        end else begin
                            r_sh  <= r_sh >> 8;
                            r_cnt <= r_cnt - ONE_BYTE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rk4_stream_packer.sv
// Scoreboard bench for rk4_stream_packer: expected bytes are queued as samples are
// accepted and checked against every tx handshake.
module tb_rk4_stream_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic [1:0]  ch_en;
    logic        abort;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [4:0]  fifo_level;
    logic [15:0] sample_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    int          nbytes = 0;
    int          abort_at = 0;
    bit          rnd = 1'b0;
    int          max_scnt = 0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [7:0]  prev_b = 8'h00;
    logic [31:0] eos_w = 32'hDEADBEEF;

    rk4_stream_packer dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .ch_en(ch_en), .abort(abort),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .busy(busy), .fifo_level(fifo_level), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int i);
        return {32'h00047AE1 + 32'(i), 32'h0000199A + (32'(i) << 16)};
    endfunction

    task automatic add_expected(input logic [63:0] d, input logic l);
        for (int k = 0; k < 2; k++)
            if (ch_en[k])
                for (int b = 0; b < 4; b++) sb.push_back(d[k*32 + b*8 +: 8]);
        if (l) for (int b = 0; b < 4; b++) sb.push_back(eos_w[b*8 +: 8]);
    endtask

    // Negative edge: observe the handshake that the next rising edge will complete.
    task automatic neg_phase();
        logic [7:0] exp_b;
        @(negedge clk);
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_byte !== prev_b) begin
                    errors++;
                    $display("FAIL hold: valid=%b byte=%h, required valid=1 byte=%h", tx_valid, tx_byte, prev_b);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, none expected", tx_byte);
                end else begin
                    exp_b = sb.pop_front();
                    if (tx_byte !== exp_b) begin
                        errors++;
                        $display("FAIL byte: got %h, required %h", tx_byte, exp_b);
                    end
                end
                nbytes++;
                if (abort_at != 0 && nbytes == abort_at) begin
                    abort = 1'b1;
                    abort_at = 0;
                end
            end
            if (int'(sample_cnt) > max_scnt) max_scnt = int'(sample_cnt);
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_b = tx_byte;
        end
    endtask

    task automatic pos_phase();
        @(posedge clk);
        #1;
        abort = 1'b0;
        if (rnd) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc();
        neg_phase();
        pos_phase();
    endtask

    task automatic push_sample(input logic [63:0] d, input logic l, input bit track);
        bit acc = 1'b0;
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && t < 3000) begin
            neg_phase();
            if (s_ready) begin
                acc = 1'b1;
                if (track) add_expected(d, l);
            end
            pos_phase();
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready=%b, required 1", s_ready);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy || tx_valid) && t < 5000) begin
            cyc();
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL drain: %0d bytes outstanding, busy=%b, required 0 and idle", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        ch_en = 2'b11; abort = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || busy !== 1'b0 ||
            fifo_level !== 5'd0 || sample_cnt !== 16'd0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b b=%h busy=%b lvl=%0d cnt=%0d rdy=%b, required all 0",
                     tx_valid, tx_byte, busy, fifo_level, sample_cnt, s_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: s_ready=%b, required 0", s_ready);
        end
        pos_phase();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        ch_en = 2'b11; tx_ready = 1'b1; max_scnt = 0;
        push_sample(mk(0), 1'b1, 1'b1);
        cyc();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: tx_valid=%b, required 0", tx_valid);
        end
        cyc();
        checks++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'h9A) begin
            errors++;
            $display("FAIL latency_n2: tx_valid=%b byte=%h, required 1 and 9a", tx_valid, tx_byte);
        end
        drain();
        checks++;
        if (max_scnt != 1 || sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_cnt: peak=%0d final=%0d, required 1 and 0", max_scnt, sample_cnt);
        end
    endtask

    task automatic test_chmask();
        int n0;
        ch_en = 2'b10; n0 = nbytes;
        push_sample(mk(0), 1'b1, 1'b1);
        drain();
        checks++;
        if (nbytes - n0 != 8) begin
            errors++;
            $display("FAIL mask10_len: %0d bytes, required 8", nbytes - n0);
        end
        ch_en = 2'b00; n0 = nbytes; max_scnt = 0;
        push_sample(mk(1), 1'b1, 1'b1);
        drain();
        checks++;
        if (nbytes - n0 != 4 || max_scnt != 1) begin
            errors++;
            $display("FAIL mask00: %0d bytes peak=%0d, required 4 and 1", nbytes - n0, max_scnt);
        end
        ch_en = 2'b11;
    endtask

    task automatic test_backpressure();
        ch_en = 2'b11; tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_sample(mk(i), 1'b0, 1'b1);
        repeat (3) cyc();
        checks++;
        if (fifo_level !== 5'd16 || s_ready !== 1'b0 || tx_valid !== 1'b1 || tx_byte !== 8'h9A) begin
            errors++;
            $display("FAIL full: lvl=%0d rdy=%b v=%b b=%h, required 16 0 1 9a",
                     fifo_level, s_ready, tx_valid, tx_byte);
        end
        s_valid = 1'b1; s_data = mk(17); s_last = 1'b1;
        repeat (5) cyc();
        checks++;
        if (fifo_level !== 5'd16 || tx_byte !== 8'h9A) begin
            errors++;
            $display("FAIL held: lvl=%0d b=%h, required 16 and 9a", fifo_level, tx_byte);
        end
        tx_ready = 1'b1;
        push_sample(mk(17), 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_random();
        ch_en = 2'b11; rnd = 1'b1; max_scnt = 0;
        for (int i = 0; i < 100; i++) push_sample(mk(i + 40), (i == 99), 1'b1);
        drain();
        rnd = 1'b0; tx_ready = 1'b1;
        checks++;
        if (max_scnt != 100 || sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL random_cnt: peak=%0d final=%0d, required 100 and 0", max_scnt, sample_cnt);
        end
    endtask

    task automatic test_abort();
        int t = 0;
        ch_en = 2'b11; tx_ready = 1'b0;
        sb.push_back(8'h9A); sb.push_back(8'h19); sb.push_back(8'h00);
        for (int b = 0; b < 4; b++) sb.push_back(eos_w[b*8 +: 8]);
        for (int i = 0; i < 6; i++) push_sample(mk(0), 1'b0, 1'b0);
        repeat (2) cyc();
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++;
            $display("FAIL abort_queued: lvl=%0d, required 5", fifo_level);
        end
        nbytes = 0; abort_at = 3; tx_ready = 1'b1;
        while (abort_at != 0 && t < 100) begin
            cyc();
            t++;
        end
        checks++;
        if (abort_at != 0 || fifo_level !== 5'd0 || tx_valid !== 1'b1 || tx_byte !== 8'hEF) begin
            errors++;
            $display("FAIL abort: lvl=%0d v=%b b=%h, required 0 1 ef", fifo_level, tx_valid, tx_byte);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        ch_en = 2'b11; tx_ready = 1'b0;
        push_sample(mk(3), 1'b1, 1'b0);
        repeat (3) cyc();
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_send: tx_valid=%b, required 1", tx_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || busy !== 1'b0 ||
            fifo_level !== 5'd0 || sample_cnt !== 16'd0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: v=%b b=%h busy=%b lvl=%0d cnt=%0d rdy=%b, required all 0",
                     tx_valid, tx_byte, busy, fifo_level, sample_cnt, s_ready);
        end
        sb.delete();
        neg_phase();
        pos_phase();
        rst_n = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: v=%b busy=%b, required 0 0", tx_valid, busy);
            end
        end
        push_sample(mk(5), 1'b1, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chmask();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
